// File: rtl/clock_calendar_core.sv
// clock_calendar_core
// Timekeeping and user-edit engine for the clock display. A prescaler
// derives a once-per-second tick from clk. That tick drives a
// time/calendar count covering the years 2000-2099. A button-driven edit
// FSM lets the user set hour, min, day, month and year. A display-mode
// selector chooses between the time, date and year views.
//
// Optional feature: define CLOCK_LEAP_YEAR_EN to give February 29 days
// when year[1:0] == 0. Without it, February always has 28 days.
//
// Parameters:
//   CLK_HZ        clk cycles per one-second tick (>= 2)
// Ports:
//   clk           system/pixel clock
//   rst           asynchronous active-high reset
//   btn_mode      1-cycle pulse, cycles display_mode (RUN only)
//   btn_set       1-cycle pulse, enters/advances edit mode
//   btn_inc       1-cycle pulse, increments the field under edit
//   btn_fmt       1-cycle pulse, toggles mode_12h
//   hour          0-23 (always 24h form)
//   min, sec      0-59
//   day           1-31
//   month         1-12
//   year          0-99 (2000+year)
//   am_pm         1 when hour >= 12
//   mode_12h      12h display format flag
//   display_mode  0 time, 1 date, 2 year
//   edit_field    FSM state: 0 run, 1 hour, 2 min, 3 day, 4 month, 5 year
module clock_calendar_core #(
    parameter int CLK_HZ = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_fmt,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       am_pm,
    output logic       mode_12h,
    output logic [1:0] display_mode,
    output logic [2:0] edit_field
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_HOUR  = 3'd1,
        S_MIN   = 3'd2,
        S_DAY   = 3'd3,
        S_MONTH = 3'd4,
        S_YEAR  = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic          tick;

    logic [4:0] hour_n;
    logic [5:0] min_n, sec_n;
    logic [4:0] day_raw, day_n;
    logic [3:0] month_n;
    logic [6:0] year_n;
    logic       mode_12h_n;
    logic [1:0] display_mode_n;
    logic       leap_cur, leap_n;
    logic [4:0] dim_cur, dim_clamp;

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = leap ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

`ifdef CLOCK_LEAP_YEAR_EN
    // Every 4th year is leap; exact across 2000-2099 since 2000 is leap.
    assign leap_cur = (year[1:0] == 2'b00);
    assign leap_n   = (year_n[1:0] == 2'b00);
`else
    assign leap_cur = 1'b0;
    assign leap_n   = 1'b0;
`endif

    assign tick      = (presc == PRESC_MAX);
    assign dim_cur   = days_in_month(month, leap_cur);
    assign dim_clamp = days_in_month(month_n, leap_n);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_n;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state;
        if (btn_set) begin
            case (state)
                S_RUN:   state_n = S_HOUR;
                S_HOUR:  state_n = S_MIN;
                S_MIN:   state_n = S_DAY;
                S_DAY:   state_n = S_MONTH;
                S_MONTH: state_n = S_YEAR;
                S_YEAR:  state_n = S_RUN;
                default: state_n = S_RUN;
            endcase
        end
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin
        presc_n    = presc;
        hour_n     = hour;
        min_n      = min;
        sec_n      = sec;
        day_raw    = day;
        month_n    = month;
        year_n     = year;
        mode_12h_n = btn_fmt ? ~mode_12h : mode_12h;

        if (state == S_RUN) begin
            if (btn_set) begin
                // Entering edit discards any coincident tick.
                sec_n   = 6'd0;
                presc_n = '0;
            end else begin
                presc_n = tick ? '0 : presc + PW'(1);
                if (tick) begin
                    // Full carry chain resolved within one edge.
                    if (sec == 6'd59) begin
                        sec_n = 6'd0;
                        if (min == 6'd59) begin
                            min_n = 6'd0;
                            if (hour == 5'd23) begin
                                hour_n = 5'd0;
                                if (day >= dim_cur) begin
                                    day_raw = 5'd1;
                                    if (month == 4'd12) begin
                                        month_n = 4'd1;
                                        year_n  = (year == 7'd99) ? 7'd0 : year + 7'd1;
                                    end else begin
                                        month_n = month + 4'd1;
                                    end
                                end else begin
                                    day_raw = day + 5'd1;
                                end
                            end else begin
                                hour_n = hour + 5'd1;
                            end
                        end else begin
                            min_n = min + 6'd1;
                        end
                    end else begin
                        sec_n = sec + 6'd1;
                    end
                end
            end
        end else begin
            // Edit states: time frozen, prescaler parked at 0 so RUN restarts cleanly.
            presc_n = '0;
            if (btn_inc && !btn_set) begin
                case (state)
                    S_HOUR:  hour_n  = (hour == 5'd23)  ? 5'd0 : hour + 5'd1;
                    S_MIN:   min_n   = (min == 6'd59)   ? 6'd0 : min + 6'd1;
                    S_DAY:   day_raw = (day >= dim_cur) ? 5'd1 : day + 5'd1;
                    S_MONTH: month_n = (month == 4'd12) ? 4'd1 : month + 4'd1;
                    S_YEAR:  year_n  = (year == 7'd99)  ? 7'd0 : year + 7'd1;
                    default: ;
                endcase
            end
        end
    end

    // Day clamp uses the post-edit month/year, so it lives in its own block.
    always_comb begin
        day_n = day_raw;
        if ((state == S_MONTH || state == S_YEAR) && (day_raw > dim_clamp))
            day_n = dim_clamp;
    end

    // Edit states force the view of the field being edited; leaving
    // SET_YEAR keeps the year view.
    always_comb begin
        display_mode_n = display_mode;
        case (state_n)
            S_HOUR, S_MIN:  display_mode_n = 2'd0;
            S_DAY, S_MONTH: display_mode_n = 2'd1;
            S_YEAR:         display_mode_n = 2'd2;
            default: begin
                if (state == S_RUN && btn_mode)
                    display_mode_n = (display_mode == 2'd2) ? 2'd0 : display_mode + 2'd1;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            hour         <= 5'd0;
            min          <= 6'd0;
            sec          <= 6'd0;
            day          <= 5'd1;
            month        <= 4'd1;
            year         <= 7'd0;
            am_pm        <= 1'b0;
            mode_12h     <= 1'b0;
            display_mode <= 2'd0;
        end else begin
            presc        <= presc_n;
            hour         <= hour_n;
            min          <= min_n;
            sec          <= sec_n;
            day          <= day_n;
            month        <= month_n;
            year         <= year_n;
            am_pm        <= (hour_n >= 5'd12);
            mode_12h     <= mode_12h_n;
            display_mode <= display_mode_n;
        end
    end

    assign edit_field = state;

endmodule

// File: tb/tb_clock_calendar_core.sv
module tb_clock_calendar_core;

    localparam int HZ = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_fmt = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic       am_pm;
    logic       mode_12h;
    logic [1:0] display_mode;
    logic [2:0] edit_field;

    int n_cmp = 0;
    int n_err = 0;

    clock_calendar_core #(.CLK_HZ(HZ)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc), .btn_fmt(btn_fmt),
        .hour(hour), .min(min), .sec(sec), .day(day), .month(month), .year(year),
        .am_pm(am_pm), .mode_12h(mode_12h), .display_mode(display_mode),
        .edit_field(edit_field)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic i, input logic m, input logic f);
        btn_set  = s;
        btn_inc  = i;
        btn_mode = m;
        btn_fmt  = f;
        @(posedge clk);
        #1;
        btn_set  = 1'b0;
        btn_inc  = 1'b0;
        btn_mode = 1'b0;
        btn_fmt  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Loads a time/date starting from reset values. Month and year are set
    // in a first pass while day is still 1 (avoids clamping), day in a second.
    task automatic load(input int h, input int mi, input int d, input int mo, input int y);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> HOUR
        incs(h);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> MIN
        incs(mi);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> DAY
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> MONTH
        incs(mo - 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> YEAR
        incs(y);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> RUN
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> HOUR
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> MIN
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> DAY
        incs(d - 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> MONTH
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> YEAR
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // -> RUN, prescaler restarts
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        wait_cycles(2);
        chk("rst_hour", 32'(hour), 0);
        chk("rst_min", 32'(min), 0);
        chk("rst_sec", 32'(sec), 0);
        chk("rst_day", 32'(day), 1);
        chk("rst_month", 32'(month), 1);
        chk("rst_year", 32'(year), 0);
        chk("rst_ampm", 32'(am_pm), 0);
        chk("rst_fmt", 32'(mode_12h), 0);
        chk("rst_disp", 32'(display_mode), 0);
        chk("rst_edit", 32'(edit_field), 0);
        rst = 1'b0;
        wait_cycles(HZ - 1);
        chk("first_tick_early", 32'(sec), 0);
        wait_cycles(1);
        chk("first_tick", 32'(sec), 1);

        // Display modes and format toggle in RUN
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mode1", 32'(display_mode), 1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mode2", 32'(display_mode), 2);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("mode0", 32'(display_mode), 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("fmt_on", 32'(mode_12h), 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("fmt_off", 32'(mode_12h), 0);

        // Edit path: hour 22 + 3 increments -> 1
        do_reset();
        load(22, 0, 1, 1, 0);
        chk("load_hour", 32'(hour), 22);
        chk("load_ampm", 32'(am_pm), 1);
        chk("load_disp", 32'(display_mode), 2);
        wait_cycles(25);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ed_state_h", 32'(edit_field), 1);
        chk("ed_disp_h", 32'(display_mode), 0);
        chk("ed_sec_clr", 32'(sec), 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ed_h23", 32'(hour), 23);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ed_h0", 32'(hour), 0);
        chk("ed_h0_ampm", 32'(am_pm), 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ed_h1", 32'(hour), 1);
        wait_cycles(30);
        chk("ed_frozen_sec", 32'(sec), 0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);  // set beats inc
        chk("ed_state_m", 32'(edit_field), 2);
        chk("ed_set_beats_inc", 32'(hour), 1);
        chk("ed_min_keep", 32'(min), 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ed_state_d", 32'(edit_field), 3);
        chk("ed_disp_d", 32'(display_mode), 1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);  // ignored while editing
        chk("ed_mode_ignored", 32'(display_mode), 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ed_state_mo", 32'(edit_field), 4);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ed_state_y", 32'(edit_field), 5);
        chk("ed_disp_y", 32'(display_mode), 2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ed_state_run", 32'(edit_field), 0);
        chk("ed_disp_run", 32'(display_mode), 2);
        chk("ed_run_sec", 32'(sec), 0);
        wait_cycles(HZ - 1);
        chk("ed_restart_early", 32'(sec), 0);
        wait_cycles(1);
        chk("ed_restart_tick", 32'(sec), 1);

        // Day clamp on month edit, then btn_set colliding with a tick
        do_reset();
        load(0, 0, 31, 3, 0);
        chk("cl_day31", 32'(day), 31);
        chk("cl_month3", 32'(month), 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("cl_state_mo", 32'(edit_field), 4);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("cl_month4", 32'(month), 4);
        chk("cl_day30", 32'(day), 30);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);  // back to RUN, prescaler 0
        wait_cycles(HZ - 1);           // tick is now asserted
        chk("col_pre_sec", 32'(sec), 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("col_state", 32'(edit_field), 1);
        chk("col_sec", 32'(sec), 0);
        chk("col_min", 32'(min), 0);

        // Full rollover 23:59:59 31/12/99 -> 00:00:00 01/01/00
        do_reset();
        load(23, 59, 31, 12, 99);
        wait_cycles(59 * HZ);
        chk("ro_pre_sec", 32'(sec), 59);
        chk("ro_pre_min", 32'(min), 59);
        chk("ro_pre_hour", 32'(hour), 23);
        chk("ro_pre_year", 32'(year), 99);
        wait_cycles(HZ);
        chk("ro_sec", 32'(sec), 0);
        chk("ro_min", 32'(min), 0);
        chk("ro_hour", 32'(hour), 0);
        chk("ro_day", 32'(day), 1);
        chk("ro_month", 32'(month), 1);
        chk("ro_year", 32'(year), 0);
        chk("ro_ampm", 32'(am_pm), 0);

        // February end, year 24 (leap when enabled)
        do_reset();
        load(23, 59, 28, 2, 24);
        wait_cycles(60 * HZ);
`ifdef CLOCK_LEAP_YEAR_EN
        chk("leap24_day", 32'(day), 29);
        chk("leap24_month", 32'(month), 2);
`else
        chk("leap24_day", 32'(day), 1);
        chk("leap24_month", 32'(month), 3);
`endif
        chk("leap24_hour", 32'(hour), 0);

        // February end, year 25 (never leap)
        do_reset();
        load(23, 59, 28, 2, 25);
        wait_cycles(60 * HZ);
        chk("feb25_day", 32'(day), 1);
        chk("feb25_month", 32'(month), 3);
        chk("feb25_year", 32'(year), 25);

        // am_pm follows hour 11 -> 12 on the same edge
        do_reset();
        load(11, 59, 1, 1, 0);
        wait_cycles(59 * HZ);
        chk("ap_pre_hour", 32'(hour), 11);
        chk("ap_pre", 32'(am_pm), 0);
        wait_cycles(HZ);
        chk("ap_hour12", 32'(hour), 12);
        chk("ap_pm", 32'(am_pm), 1);

        // Reset mid-edit returns everything to defaults
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        do_reset();
        chk("rst2_edit", 32'(edit_field), 0);
        chk("rst2_hour", 32'(hour), 0);
        chk("rst2_fmt", 32'(mode_12h), 0);
        chk("rst2_disp", 32'(display_mode), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
